// File: rtl/square.sv
// square -- iterative unsigned squarer, y = x*x.
//
// Shift-and-add over WIDTH operand bits. Each bit takes two cycles: ADD, then
// SHIFT. The shared start/busy handshake lets this block sit in the same slots
// as the iterative square-root unit. A registered one-cycle done pulse marks
// the edge at which y_bo is updated.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active high
//   x_bi     unsigned operand, sampled only on the accepting edge
//   start_i  request, honoured only while idle
//   busy_o   high while a computation is in progress (state != IDLE)
//   done_o   one-cycle pulse, first IDLE cycle after FINISH
//   y_bo     result register, held until the next completion
module square #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   x_bi,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FINISH} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a;     // multiplicand, shifted left once per bit
  logic [WIDTH-1:0]   b;     // multiplier, LSB selects the add
  logic [CW-1:0]      cnt;   // bits still to process

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      acc    <= '0;
      a      <= '0;
      b      <= '0;
      cnt    <= '0;
      y_bo   <= '0;
      done_o <= 1'b0;
    end else begin
      // Pulse only on the FINISH -> IDLE edge.
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            a     <= {{WIDTH{1'b0}}, x_bi};
            b     <= x_bi;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= ADD;
          end
        end
        ADD: begin
          // (2^W-1)^2 < 2^(2W), so the sum never carries out.
          if (b[0]) acc <= acc + a;
          state <= SHIFT;
        end
        SHIFT: begin
          a     <= a << 1;
          b     <= b >> 1;
          cnt   <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? FINISH : ADD;
        end
        FINISH: begin
          y_bo   <= acc;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
